// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the hazard/forwarding controller: operand-mux select encoding,
// shadow-pipeline stage metadata and the stage-to-stage advance helpers.
package hazard_fwd_unit_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_NORMAL   = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_BRANCH   = 2'd2,
        HZ_MEM_WAIT = 2'd3
    } hazard_e;

    typedef struct packed {
        logic     valid;
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_read;
        logic     mem_req;
    } ex_meta_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_req;
    } mem_meta_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
    } wb_meta_t;

    // A slot can supply a forwarded value only if it really writes a non-x0 register.
    function automatic logic writes_reg(input logic valid, input logic reg_write,
                                        input reg_idx_t rd);
        return valid & reg_write & (rd != '0);
    endfunction

    function automatic mem_meta_t ex_to_mem(input ex_meta_t e);
        mem_meta_t m;
        m.valid     = e.valid;
        m.rd        = e.rd;
        m.reg_write = e.reg_write;
        m.mem_req   = e.mem_req;
        return m;
    endfunction

    function automatic wb_meta_t mem_to_wb(input mem_meta_t m);
        wb_meta_t w;
        w.valid     = m.valid;
        w.rd        = m.rd;
        w.reg_write = m.reg_write;
        return w;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Operand forward select for one execute-stage source index; the M-stage result
// is newer than the W-stage result, so it wins when both match.
module hazard_fwd_unit_fwd_select
    import hazard_fwd_unit_pkg::*;
(
    input  reg_idx_t src,
    input  logic     mem_valid,
    input  logic     mem_reg_write,
    input  reg_idx_t mem_rd,
    input  logic     wb_valid,
    input  logic     wb_reg_write,
    input  reg_idx_t wb_rd,
    output fwd_sel_e sel
);

    always_comb begin
        sel = FWD_RF;
        if (writes_reg(mem_valid, mem_reg_write, mem_rd) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (writes_reg(wb_valid, wb_reg_write, wb_rd) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: shadows E/M/W register
// metadata and drives operand forward selects plus stall/flush controls.
module hazard_fwd_unit #(
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_d,
    input  logic [REG_IDX_W-1:0] rs1_d,
    input  logic [REG_IDX_W-1:0] rs2_d,
    input  logic                 use_rs1_d,
    input  logic                 use_rs2_d,
    input  logic [REG_IDX_W-1:0] rd_d,
    input  logic                 reg_write_d,
    input  logic                 mem_read_d,
    input  logic                 mem_write_d,
    input  logic                 branch_taken_e,
    input  logic                 dmem_ready,
    output logic [1:0]           fwd_a_e,
    output logic [1:0]           fwd_b_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 flush_d,
    output logic                 flush_e
);

    import hazard_fwd_unit_pkg::*;

    ex_meta_t  ex_meta_p0;
    mem_meta_t mem_meta_p1;
    wb_meta_t  wb_meta_p2;
    ex_meta_t  ex_from_d;
    hazard_e   hazard;
    logic      mem_wait;
    logic      load_use;
    fwd_sel_e  sel_a;
    fwd_sel_e  sel_b;

    always_comb begin
        ex_from_d.valid     = valid_d;
        ex_from_d.rs1       = rs1_d;
        ex_from_d.rs2       = rs2_d;
        ex_from_d.rd        = rd_d;
        ex_from_d.reg_write = reg_write_d;
        ex_from_d.mem_read  = mem_read_d;
        ex_from_d.mem_req   = mem_read_d | mem_write_d;
    end

    assign mem_wait = mem_meta_p1.valid & mem_meta_p1.mem_req & ~dmem_ready;

    assign load_use = valid_d & ex_meta_p0.valid & ex_meta_p0.mem_read
                    & (ex_meta_p0.rd != '0)
                    & ((use_rs1_d & (rs1_d == ex_meta_p0.rd))
                     | (use_rs2_d & (rs2_d == ex_meta_p0.rd)));

    // Reset also silences a live branch_taken_e so every control output reads 0 at once.
    always_comb begin
        hazard = HZ_NORMAL;
        if (!rst_n) begin
            hazard = HZ_NORMAL;
        end else if (mem_wait) begin
            hazard = HZ_MEM_WAIT;
        end else if (branch_taken_e) begin
            hazard = HZ_BRANCH;
        end else if (load_use) begin
            hazard = HZ_LOAD_USE;
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        case (hazard)
            HZ_MEM_WAIT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end
            HZ_BRANCH: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
            HZ_LOAD_USE: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage boundary D -> E -> M -> W. During a memory wait E and M hold (keeping any
    // branch in E for re-presentation) while W drains to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_meta_p0  <= '0;
            mem_meta_p1 <= '0;
            wb_meta_p2  <= '0;
        end else begin
            case (hazard)
                HZ_MEM_WAIT: begin
                    wb_meta_p2 <= '0;
                end
                HZ_BRANCH, HZ_LOAD_USE: begin
                    ex_meta_p0  <= '0;
                    mem_meta_p1 <= ex_to_mem(ex_meta_p0);
                    wb_meta_p2  <= mem_to_wb(mem_meta_p1);
                end
                default: begin
                    ex_meta_p0  <= ex_from_d;
                    mem_meta_p1 <= ex_to_mem(ex_meta_p0);
                    wb_meta_p2  <= mem_to_wb(mem_meta_p1);
                end
            endcase
        end
    end

    hazard_fwd_unit_fwd_select u_fwd_select_a (
        .src           (ex_meta_p0.rs1),
        .mem_valid     (mem_meta_p1.valid),
        .mem_reg_write (mem_meta_p1.reg_write),
        .mem_rd        (mem_meta_p1.rd),
        .wb_valid      (wb_meta_p2.valid),
        .wb_reg_write  (wb_meta_p2.reg_write),
        .wb_rd         (wb_meta_p2.rd),
        .sel           (sel_a)
    );

    hazard_fwd_unit_fwd_select u_fwd_select_b (
        .src           (ex_meta_p0.rs2),
        .mem_valid     (mem_meta_p1.valid),
        .mem_reg_write (mem_meta_p1.reg_write),
        .mem_rd        (mem_meta_p1.rd),
        .wb_valid      (wb_meta_p2.valid),
        .wb_reg_write  (wb_meta_p2.reg_write),
        .wb_rd         (wb_meta_p2.rd),
        .sel           (sel_b)
    );

    assign fwd_a_e = sel_a;
    assign fwd_b_e = sel_b;

endmodule
